// File: rtl/wave_seq.sv
// Waveform program sequencer: replays a host-loaded table of {mode, param1, param2, duration}
// entries as register writes to a wave generator; one write per cycle, no backpressure from the generator.
module wave_seq #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  h_wstrb,
  input  logic [31:0] h_addr,
  input  logic [31:0] h_wdata,
  output logic [31:0] h_rdata,
  output logic [3:0]  wg_wstrb,
  output logic [31:0] wg_addr,
  output logic [31:0] wg_wdata,
  output logic        busy,
  output logic        done
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_MODE = 3'd1;
  localparam logic [2:0] WR_P1   = 3'd2;
  localparam logic [2:0] WR_P2   = 3'd3;
  localparam logic [2:0] DWELL   = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  typedef struct packed {
    logic [2:0]  mode;
    logic [31:0] param1;
    logic [31:0] param2;
    logic [31:0] duration;
  } entry_t;

  entry_t        tbl [DEPTH];
  logic [2:0]    state, state_nxt;
  logic [3:0]    idx, idx_nxt;
  logic [15:0]   loop_cnt, loop_cnt_nxt;
  logic [31:0]   dwell_cnt, dwell_cnt_nxt;
  logic          loop_en;
  logic [3:0]    count;

  logic          h_wr;
  logic          ctrl_wr;
  logic          count_wr;
  logic          start_cmd;
  logic          stop_cmd;
  logic [IW-1:0] h_ent;
  logic [IW-1:0] cur_ent;
  entry_t        cur;
  logic [31:0]   dur_eff;
  logic          dwell_last;
  logic          addr_unused;

  assign h_wr      = |h_wstrb;
  assign ctrl_wr   = h_wr && !h_addr[7] && (h_addr[3:2] == 2'd0);
  assign count_wr  = h_wr && !h_addr[7] && (h_addr[3:2] == 2'd1);
  // Stop takes priority when both command bits arrive in one write.
  assign stop_cmd  = ctrl_wr && h_wdata[1];
  assign start_cmd = ctrl_wr && h_wdata[0] && !h_wdata[1];

  assign h_ent       = h_addr[4 +: IW];
  assign cur_ent     = idx[IW-1:0];
  assign cur         = tbl[cur_ent];
  assign dur_eff     = (cur.duration == 32'd0) ? 32'd1 : cur.duration;
  assign dwell_last  = (dwell_cnt >= (dur_eff - 32'd1));
  assign addr_unused = ^{h_addr[31:8], h_addr[6:4], h_addr[1:0]};

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    loop_cnt_nxt  = loop_cnt;
    dwell_cnt_nxt = dwell_cnt;
    case (state)
      IDLE: begin
        if (start_cmd) begin
          state_nxt    = WR_MODE;
          idx_nxt      = 4'd0;
          loop_cnt_nxt = 16'd0;
        end
      end
      WR_MODE: state_nxt = WR_P1;
      WR_P1:   state_nxt = WR_P2;
      WR_P2: begin
        state_nxt     = DWELL;
        dwell_cnt_nxt = 32'd0;
      end
      DWELL: begin
        if (dwell_last) begin
          if ((idx + 4'd1) < count) begin
            idx_nxt   = idx + 4'd1;
            state_nxt = WR_MODE;
          end else if (loop_en) begin
            idx_nxt   = 4'd0;
            state_nxt = WR_MODE;
            if (loop_cnt != 16'hFFFF) loop_cnt_nxt = loop_cnt + 16'd1;
          end else begin
            state_nxt = FIN;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + 32'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (stop_cmd && (state != IDLE)) state_nxt = FIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      loop_cnt  <= 16'd0;
      dwell_cnt <= 32'd0;
      loop_en   <= 1'b0;
      count     <= 4'd1;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      loop_cnt  <= loop_cnt_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      if (ctrl_wr) loop_en <= h_wdata[2];
      if (count_wr) begin
        if (h_wdata == 32'd0)
          count <= 4'd1;
        else if (h_wdata > 32'(DEPTH))
          count <= 4'(DEPTH);
        else
          count <= h_wdata[3:0];
      end
      if (h_wr && h_addr[7]) begin
        case (h_addr[3:2])
          2'd0: tbl[h_ent].mode     <= h_wdata[2:0];
          2'd1: tbl[h_ent].param1   <= h_wdata;
          2'd2: tbl[h_ent].param2   <= h_wdata;
          2'd3: tbl[h_ent].duration <= h_wdata;
          default: ;
        endcase
      end
    end
  end

  // Generator outputs depend only on registered state and table contents.
  always_comb begin
    wg_wstrb = 4'h0;
    wg_addr  = 32'd0;
    wg_wdata = 32'd0;
    case (state)
      WR_MODE: begin
        wg_wstrb = 4'hF;
        wg_addr  = 32'h0;
        wg_wdata = {29'b0, cur.mode};
      end
      WR_P1: begin
        wg_wstrb = 4'hF;
        wg_addr  = 32'h4;
        wg_wdata = cur.param1;
      end
      WR_P2: begin
        wg_wstrb = 4'hF;
        wg_addr  = 32'h8;
        wg_wdata = cur.param2;
      end
      FIN: begin
        wg_wstrb = 4'hF;
        wg_addr  = 32'h0;
        wg_wdata = 32'd0;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_comb begin
    h_rdata = 32'd0;
    if (h_addr[7]) begin
      case (h_addr[3:2])
        2'd0: h_rdata = {29'b0, tbl[h_ent].mode};
        2'd1: h_rdata = tbl[h_ent].param1;
        2'd2: h_rdata = tbl[h_ent].param2;
        2'd3: h_rdata = tbl[h_ent].duration;
        default: h_rdata = 32'd0;
      endcase
    end else begin
      case (h_addr[3:2])
        2'd0: h_rdata = {29'b0, loop_en, 2'b0};
        2'd1: h_rdata = {28'b0, count};
        2'd2: h_rdata = {loop_cnt, 8'b0, idx, 3'b0, busy};
        default: h_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_seq.sv
// Directed bench for wave_seq: hand-computed generator write sequences and host readbacks.
module tb_wave_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  h_wstrb;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic [31:0] h_rdata;
  logic [3:0]  wg_wstrb;
  logic [31:0] wg_addr;
  logic [31:0] wg_wdata;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  wave_seq #(.DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .h_wstrb  (h_wstrb),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_rdata  (h_rdata),
    .wg_wstrb (wg_wstrb),
    .wg_addr  (wg_addr),
    .wg_wdata (wg_wdata),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic hwr_s(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    h_addr  = a;
    h_wdata = d;
    h_wstrb = s;
    tick();
    h_wstrb = 4'h0;
  endtask

  task automatic hwr(input logic [31:0] a, input logic [31:0] d);
    hwr_s(a, d, 4'hF);
  endtask

  task automatic hrd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    h_addr = a;
    #1;
    chk(tag, h_rdata, exp);
  endtask

  task automatic wg_chk(input string tag, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic b, input logic dn);
    chk({tag, "_strb"}, {28'b0, wg_wstrb}, {28'b0, s});
    chk({tag, "_addr"}, wg_addr, a);
    chk({tag, "_data"}, wg_wdata, d);
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, b});
    chk({tag, "_done"}, {31'b0, done}, {31'b0, dn});
  endtask

  task automatic prog(input int e, input logic [31:0] m, input logic [31:0] p1,
                      input logic [31:0] p2, input logic [31:0] dur);
    hwr(32'h80 + 32'(e * 16), m);
    hwr(32'h84 + 32'(e * 16), p1);
    hwr(32'h88 + 32'(e * 16), p2);
    hwr(32'h8C + 32'(e * 16), dur);
  endtask

  initial begin
    reset   = 1'b1;
    h_wstrb = 4'h0;
    h_addr  = 32'd0;
    h_wdata = 32'd0;
    tick();
    tick();
    wg_chk("rst", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    wg_chk("idle", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    hrd_chk("rst_ctrl", 32'h00, 32'h0);
    hrd_chk("rst_count", 32'h04, 32'h1);
    hrd_chk("rst_status", 32'h08, 32'h0);
    hrd_chk("rst_tbl", 32'hBC, 32'h0);
    tick();

    // Two-entry program, single pass
    prog(0, 32'd1, 32'd5, 32'd0, 32'd3);
    prog(1, 32'd2, 32'd4, 32'd6, 32'd0);
    hwr(32'h04, 32'd2);
    hrd_chk("tbl_rb", 32'h94, 32'd4);
    hrd_chk("rsv_rd", 32'h0C, 32'd0);
    hwr(32'h00, 32'h1);
    wg_chk("e0_mode", 4'hF, 32'h0, 32'd1, 1'b1, 1'b0);
    tick();
    wg_chk("e0_p1", 4'hF, 32'h4, 32'd5, 1'b1, 1'b0);
    tick();
    wg_chk("e0_p2", 4'hF, 32'h8, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wg_chk("e0_dwell", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    tick();
    wg_chk("e1_mode", 4'hF, 32'h0, 32'd2, 1'b1, 1'b0);
    hrd_chk("e1_status", 32'h08, 32'h0000_0011);
    tick();
    wg_chk("e1_p1", 4'hF, 32'h4, 32'd4, 1'b1, 1'b0);
    tick();
    wg_chk("e1_p2", 4'hF, 32'h8, 32'd6, 1'b1, 1'b0);
    tick();
    wg_chk("e1_dwell", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    wg_chk("fin", 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    wg_chk("end_idle", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Looping: a pass is 10 cycles; cycle 25 is the last dwell of entry0 in pass 3
    hwr(32'h00, 32'h5);
    repeat (25) tick();
    hrd_chk("loop_status", 32'h08, 32'h0002_0001);
    wg_chk("loop_dwell", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    hwr(32'h00, 32'h6);
    wg_chk("stop_fin", 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    hrd_chk("loop_en_rb", 32'h00, 32'h4);
    tick();
    wg_chk("stop_idle", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    hwr(32'h00, 32'h0);

    // COUNT clamping and single-strobe write
    hwr(32'h04, 32'd0);
    hrd_chk("count_0", 32'h04, 32'd1);
    hwr(32'h04, 32'd20);
    hrd_chk("count_20", 32'h04, 32'd8);
    hwr(32'h04, 32'd8);
    hrd_chk("count_8", 32'h04, 32'd8);
    hwr_s(32'h04, 32'd3, 4'b0100);
    hrd_chk("count_strb", 32'h04, 32'd3);
    hwr(32'h04, 32'd2);

    // Start while busy is ignored
    hwr(32'h00, 32'h1);
    repeat (9) tick();
    wg_chk("ign_dwell", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    hwr(32'h00, 32'h1);
    wg_chk("ign_fin", 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    hrd_chk("ign_status", 32'h08, 32'h0000_0011);
    tick();
    wg_chk("ign_idle", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    hwr(32'h00, 32'h3);
    wg_chk("ss_idle0", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    wg_chk("ss_idle1", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Reset in WR_P1 aborts without a FIN write
    hwr(32'h00, 32'h1);
    tick();
    wg_chk("pre_rst", 4'hF, 32'h4, 32'd5, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    wg_chk("rst_mid", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    wg_chk("rst_hold", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    hrd_chk("rst_tbl0", 32'h84, 32'h0);
    hrd_chk("rst_cnt", 32'h04, 32'd1);
    tick();
    wg_chk("post_rst", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Duration rewritten from 10 to 2 while entry0 is in WR_MODE
    prog(0, 32'd3, 32'hA, 32'hB, 32'd10);
    hwr(32'h00, 32'h1);
    wg_chk("d_mode", 4'hF, 32'h0, 32'd3, 1'b1, 1'b0);
    hwr(32'h8C, 32'd2);
    wg_chk("d_p1", 4'hF, 32'h4, 32'hA, 1'b1, 1'b0);
    tick();
    wg_chk("d_p2", 4'hF, 32'h8, 32'hB, 1'b1, 1'b0);
    tick();
    wg_chk("d_dwell0", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    wg_chk("d_dwell1", 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    wg_chk("d_fin", 4'hF, 32'h0, 32'h0, 1'b1, 1'b1);
    tick();
    wg_chk("d_idle", 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_seq.md
WAVE_SEQ -- requirements
Module: wave_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of program table entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port h_wstrb  input  4  host write strobe; any bit set = host write this cycle.
REQ-005 SHALL have port h_addr  input  32  host byte address; only h_addr[7:2] decoded.
REQ-006 SHALL have port h_wdata  input  32  host write data.
REQ-007 SHALL have port h_rdata  output  32  host read data, combinational from h_addr.
REQ-008 SHALL have port wg_wstrb  output  4  write strobe to wave generator register port.
REQ-009 SHALL have port wg_addr  output  32  wave generator register address.
REQ-010 SHALL have port wg_wdata  output  32  wave generator write data.
REQ-011 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a sequence ends.

Function
REQ-013 Host map, h_addr[7]=0: 0x00 CTRL (W: bit0 start, bit1 stop, bit2 loop_en; R: {29'b0, loop_en, 2'b0}), 0x04 COUNT, 0x08 STATUS (R only), 0x0C reserved (reads 0).
REQ-014 Host map, h_addr[7]=1: entry index = h_addr[6:4] mod DEPTH; field h_addr[3:2]: 0 mode[2:0], 1 param1, 2 param2, 3 duration; all R/W.
REQ-015 COUNT write SHALL clamp: 0 -> 1, >DEPTH -> DEPTH; readback returns clamped value.
REQ-016 STATUS SHALL read {loop_cnt[15:0], 8'b0, idx[3:0], 3'b0, busy}.
REQ-017 FSM states: IDLE, WR_MODE, WR_P1, WR_P2, DWELL, FIN; each non-DWELL state lasts exactly one cycle.
REQ-018 IDLE -> WR_MODE on start write; idx <= 0, loop_cnt <= 0; start while busy SHALL be ignored.
REQ-019 WR_MODE: wg_wstrb=4'hF, wg_addr=0x0, wg_wdata={29'b0, table[idx].mode}; -> WR_P1.
REQ-020 WR_P1: wg_wstrb=4'hF, wg_addr=0x4, wg_wdata=table[idx].param1; -> WR_P2.
REQ-021 WR_P2: wg_wstrb=4'hF, wg_addr=0x8, wg_wdata=table[idx].param2; -> DWELL, dwell counter <= 0.
REQ-022 DWELL SHALL last max(duration,1) cycles (32-bit counter, no wrap); on final cycle: idx<COUNT-1 -> idx+1, WR_MODE; else loop_en -> idx 0, loop_cnt+1 (saturates 0xFFFF), WR_MODE; else FIN.
REQ-023 FIN: wg_wstrb=4'hF, wg_addr=0x0, wg_wdata=0 (OFF); done=1; -> IDLE.
REQ-024 In all states other than WR_MODE/WR_P1/WR_P2/FIN, wg_wstrb=0, wg_addr=0, wg_wdata=0.
REQ-025 wg_* and done SHALL be decoded from registered state/idx only (no host-input combinational path).
REQ-026 Stop write in any non-IDLE state SHALL force next state FIN; stop in IDLE ignored; start+stop in same write: stop wins (no start).
REQ-027 Table fields SHALL be read at the state that issues them; host table writes while busy take effect when that field is next issued.
REQ-028 loop_en cleared while running SHALL end sequence after current pass (last entry DWELL -> FIN).
REQ-029 Host write to CTRL and FSM transition in the same cycle: FSM transition from current state, host command applied per REQ-018/026.

Reset
REQ-030 On reset: state IDLE, idx 0, loop_cnt 0, loop_en 0, COUNT 1, all table fields 0, dwell counter 0, busy 0, done 0, wg_* 0.
REQ-031 Reset asserted mid-sequence SHALL abort immediately with no FIN write issued.

Verification
REQ-032 COUNT=2, entry0 {mode 1, p1 5, p2 0, dur 3}, entry1 {mode 2, p1 4, p2 6, dur 0}, start -> writes (0x0,1),(0x4,5),(0x8,0), 3 DWELL cycles, (0x0,2),(0x4,4),(0x8,6), 1 DWELL cycle, FIN (0x0,0), done pulse, busy 0.
REQ-033 Same program, loop_en=1 -> after 3 passes STATUS.loop_cnt=2; stop write -> FIN next cycle, done pulse.
REQ-034 COUNT writes 0 and 20 (DEPTH 8) -> readback 1 and 8.
REQ-035 Start during DWELL -> ignored, idx/loop_cnt unchanged; start+stop in IDLE -> remains IDLE, no wg write.
REQ-036 Reset asserted during WR_P1 -> next cycle busy=0, wg_wstrb=0, table cleared, no done pulse.
REQ-037 Entry0 duration changed from 10 to 2 while in WR_MODE of entry0 -> DWELL lasts 2 cycles.
